aes_encipher_block: RTL and testbench

Iterative AES encryption datapath for 128-, 192- and 256-bit keys. It is the forward-direction counterpart of the decipher round block. It consumes round keys from the key memory, indexed by its `round` output, and substitutes one 32-bit word per cycle through an external shared forward S-box. It sits beside the key memory and decipher block under the AES core wrapper.

---
 rtl/aes_encipher_block.sv | 150 +++++++++++++++
 tb/tb_aes_encipher_block.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath for 128/192/256-bit keys. Each round takes five cycles:
// four cycles that each pass one state word through the shared S-box, then one linear-layer cycle.
module aes_encipher_block (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic [1:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_INIT,
      CTRL_SBOX,
      CTRL_MAIN
   } ctrl_t;

   ctrl_t        state;
   logic [31:0]  w0, w1, w2, w3;
   logic [1:0]   sword_ctr;
   logic [3:0]   round_ctr;
   logic [3:0]   num_rounds;
   logic         ready_reg;
   logic [127:0] shifted;
   logic [127:0] mixed;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   function automatic logic [31:0] mix_word(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = w;
      return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
              b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [31:0] c0, c1, c2, c3;
      {c0, c1, c2, c3} = s;
      return {c0[31:24], c1[23:16], c2[15:8], c3[7:0],
              c1[31:24], c2[23:16], c3[15:8], c0[7:0],
              c2[31:24], c3[23:16], c0[15:8], c1[7:0],
              c3[31:24], c0[23:16], c1[15:8], c2[7:0]};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
   endfunction

   always_comb begin
      case (keylen)
         2'd1:    num_rounds = 4'd12;
         2'd2:    num_rounds = 4'd14;
         default: num_rounds = 4'd10;
      endcase
   end

   assign new_block = {w0, w1, w2, w3};
   assign round     = round_ctr;
   assign ready     = ready_reg;

   always_comb begin
      shifted = shift_rows(new_block);
      mixed   = mix_columns(shifted);
   end

   // The S-box port is driven only while substituting, leaving it free for key expansion otherwise.
   always_comb begin
      sboxw = 32'h0;
      if (state == CTRL_SBOX) begin
         case (sword_ctr)
            2'd0:    sboxw = w0;
            2'd1:    sboxw = w1;
            2'd2:    sboxw = w2;
            default: sboxw = w3;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w0        <= 32'h0;
         w1        <= 32'h0;
         w2        <= 32'h0;
         w3        <= 32'h0;
         sword_ctr <= 2'd0;
         round_ctr <= 4'd0;
         ready_reg <= 1'b1;
         state     <= CTRL_IDLE;
      end else begin
         case (state)
            CTRL_IDLE: begin
               if (next) begin
                  round_ctr <= 4'd0;
                  ready_reg <= 1'b0;
                  state     <= CTRL_INIT;
               end
            end

            CTRL_INIT: begin
               {w0, w1, w2, w3} <= block ^ round_key;
               sword_ctr        <= 2'd0;
               round_ctr        <= 4'd1;
               state            <= CTRL_SBOX;
            end

            CTRL_SBOX: begin
               case (sword_ctr)
                  2'd0:    w0 <= new_sboxw;
                  2'd1:    w1 <= new_sboxw;
                  2'd2:    w2 <= new_sboxw;
                  default: w3 <= new_sboxw;
               endcase
               sword_ctr <= sword_ctr + 2'd1;
               if (sword_ctr == 2'd3)
                  state <= CTRL_MAIN;
            end

            CTRL_MAIN: begin
               // Final round skips MixColumns; round_ctr is left at Nr for the key memory.
               if (round_ctr < num_rounds) begin
                  {w0, w1, w2, w3} <= mixed ^ round_key;
                  round_ctr        <= round_ctr + 4'd1;
                  state            <= CTRL_SBOX;
               end else begin
                  {w0, w1, w2, w3} <= shifted ^ round_key;
                  ready_reg        <= 1'b1;
                  state            <= CTRL_IDLE;
               end
            end

            default: state <= CTRL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed bench for aes_encipher_block using the FIPS-197 appendix C vectors, with a
// behavioural S-box and key schedule feeding the DUT's S-box and round-key ports.
module tb_aes_encipher_block;

   logic         clk = 1'b0;
   logic         reset;
   logic         next;
   logic [1:0]   keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   logic [7:0]   sbox [0:255];
   logic [127:0] rk   [0:15];
   int           n_checks = 0;
   int           n_fail   = 0;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   always #5 clk = ~clk;

   always_comb round_key = rk[round];
   always_comb new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]], sbox[sboxw[15:8]], sbox[sboxw[7:0]]};

   aes_encipher_block dut (
      .clk       (clk),
      .reset     (reset),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
   endfunction

   function automatic int nr_of(input logic [1:0] kl);
      return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
   endfunction

   // Key bytes are 00,01,02,... for every key length, as in the FIPS-197 appendix C examples.
   task automatic expand_key(input logic [1:0] kl);
      logic [31:0] ew [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr, nk;
      nr = nr_of(kl);
      nk = nr - 6;
      for (int i = 0; i < nk; i++)
         ew[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      rc = 8'h01;
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = ew[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         ew[i] = ew[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk[r] = (r <= nr) ? {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]} : 128'h0;
   endtask

   // Leaves the bench in the INIT cycle, right after the edge that sampled next.
   task automatic start_op(input logic [1:0] kl, input bit hold);
      keylen = kl;
      block  = PT;
      expand_key(kl);
      next   = 1'b1;
      tick();
      if (!hold) next = 1'b0;
   endtask

   task automatic finish_op(input string tag, input logic [1:0] kl, input logic [127:0] ct, input bit pulse);
      int nr, m, lat, rv, sv, j;
      nr  = nr_of(kl);
      m   = 0;
      lat = -1;
      rv  = 0;
      sv  = 0;
      while (m <= 5*nr + 10) begin
         if (ready === 1'b1) begin
            lat = m;
            break;
         end
         if (m == 0) begin
            if (round !== 4'd0) rv++;
            if (sboxw !== 32'h0) sv++;
         end else begin
            j = m - 1;
            if (round !== 4'(j/5 + 1)) rv++;
            if (j % 5 == 4 && sboxw !== 32'h0) sv++;
         end
         if (pulse) next = (m == 4 || m == 29);
         tick();
         m++;
      end
      if (pulse) next = 1'b0;
      chk({tag, "_latency"}, 128'(lat), 128'(1 + 5*nr));
      chk({tag, "_ct"}, new_block, ct);
      chk({tag, "_final_round"}, 128'(round), 128'(nr));
      chk({tag, "_idle_sboxw"}, 128'(sboxw), 128'h0);
      chk({tag, "_round_seq_errs"}, 128'(rv), 128'h0);
      chk({tag, "_sboxw_errs"}, 128'(sv), 128'h0);
   endtask

   initial begin
      reset  = 1'b1;
      next   = 1'b0;
      keylen = 2'd0;
      block  = 128'h0;
      for (int r = 0; r < 16; r++) rk[r] = 128'h0;
      build_sbox();
      repeat (2) tick();
      chk("rst_ready", 128'(ready), 128'h1);
      chk("rst_block", new_block, 128'h0);
      chk("rst_round", 128'(round), 128'h0);
      chk("rst_sboxw", 128'(sboxw), 128'h0);
      reset = 1'b0;
      tick();

      start_op(2'd0, 1'b0);
      finish_op("aes128", 2'd0, CT128, 1'b0);
      repeat (3) tick();
      chk("idle_hold_block", new_block, CT128);
      chk("idle_hold_ready", 128'(ready), 128'h1);

      start_op(2'd1, 1'b0);
      finish_op("aes192", 2'd1, CT192, 1'b0);
      start_op(2'd2, 1'b0);
      finish_op("aes256", 2'd2, CT256, 1'b0);
      start_op(2'd3, 1'b0);
      finish_op("keylen3", 2'd3, CT128, 1'b0);

      start_op(2'd0, 1'b0);
      finish_op("busy_next", 2'd0, CT128, 1'b1);

      start_op(2'd0, 1'b1);
      finish_op("b2b_first", 2'd0, CT128, 1'b0);
      tick();
      chk("b2b_ready_pulse", 128'(ready), 128'h0);
      finish_op("b2b_second", 2'd0, CT128, 1'b0);
      next = 1'b0;
      repeat (2) tick();
      chk("b2b_no_third", 128'(ready), 128'h1);

      start_op(2'd2, 1'b0);
      repeat (20) tick();
      chk("pre_rst_busy", 128'(ready), 128'h0);
      reset = 1'b1;
      #1;
      chk("mid_rst_block", new_block, 128'h0);
      chk("mid_rst_ready", 128'(ready), 128'h1);
      chk("mid_rst_round", 128'(round), 128'h0);
      chk("mid_rst_sboxw", 128'(sboxw), 128'h0);
      tick();
      reset = 1'b0;
      start_op(2'd0, 1'b0);
      finish_op("after_rst", 2'd0, CT128, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
